// File: rtl/sipo_deserializer_pkg.sv
// Shared serial-link constants used by the link transmitter and this receiver.
package sipo_deserializer_pkg;

    // Bits per serial word on the team's serial link.
    localparam int unsigned SERIAL_WORD_W = 4;

endpackage : sipo_deserializer_pkg

// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out link bundle: serial side, parallel valid/ready side, status.
interface sipo_deserializer_if
    import sipo_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_WORD_W
) ();

    logic             serial_in;
    logic             sample_en;
    logic             clear;
    logic             data_ready;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;
    logic             overrun;

    // Upstream/downstream environment: drives the serial bits and the ready.
    modport master (
        output serial_in,
        output sample_en,
        output clear,
        output data_ready,
        input  data_out,
        input  data_valid,
        input  busy,
        input  overrun
    );

    // The deserializer itself.
    modport slave (
        input  serial_in,
        input  sample_en,
        input  clear,
        input  data_ready,
        output data_out,
        output data_valid,
        output busy,
        output overrun
    );

endinterface : sipo_deserializer_if

// File: rtl/sipo_deserializer.sv
// Receive end of the LSB-first serial link: assembles WIDTH-bit words and
// presents them on a valid/ready interface with a sticky overrun flag.
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_WORD_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sipo_deserializer_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned SHR_W = WIDTH - 1;

    // Only the WIDTH-1 most recent bits are kept: the oldest bit of a full
    // WIDTH-bit shift register would be shifted out without ever being read.
    logic [SHR_W-1:0] r_shift;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_busy;
    logic             r_overrun;

    logic [SHR_W-1:0] w_shift_nxt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_valid_nxt;
    logic             w_overrun_nxt;
    logic [WIDTH-1:0] w_assembled;
    logic             w_last_bit;
    logic             w_can_load;

    // Word as it stands after taking the current serial bit.
    assign w_assembled = {bus.serial_in, r_shift};
    assign w_last_bit  = (r_bit_cnt == CNT_W'(WIDTH - 1));
    // The output slot is free if empty or being emptied this cycle.
    assign w_can_load  = ~r_valid | bus.data_ready;

    // Next-state: handshake retire first, then clear/shift/complete.
    always_comb begin
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_data_nxt    = r_data;
        w_valid_nxt   = r_valid;
        w_overrun_nxt = r_overrun;

        if (r_valid && bus.data_ready) begin
            w_valid_nxt = 1'b0;
        end

        if (bus.clear) begin
            w_shift_nxt   = '0;
            w_bit_cnt_nxt = '0;
            w_overrun_nxt = 1'b0;
        end else if (bus.sample_en) begin
            w_shift_nxt = w_assembled[WIDTH-1:1];
            if (w_last_bit) begin
                w_bit_cnt_nxt = '0;
                if (w_can_load) begin
                    w_data_nxt  = w_assembled;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_overrun_nxt = 1'b1;
                end
            end else begin
                w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
            end
        end
    end

    // State and output registers; busy tracks the next bit count so it is registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= (w_bit_cnt_nxt != '0);
            r_overrun <= w_overrun_nxt;
        end
    end

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.busy       = r_busy;
    assign bus.overrun    = r_overrun;

endmodule : sipo_deserializer

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer (WIDTH=4 and WIDTH=8 instances).
module tb_sipo_deserializer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sipo_deserializer_if #(.WIDTH(4)) if4 ();
    sipo_deserializer_if #(.WIDTH(8)) if8 ();

    sipo_deserializer #(.WIDTH(4)) u_dut4 (.clk(clk), .reset_n(reset_n), .bus(if4));
    sipo_deserializer #(.WIDTH(8)) u_dut8 (.clk(clk), .reset_n(reset_n), .bus(if8));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model for the 4-bit instance: a queue of received bits and the output slot.
    bit       m_bits[$];
    logic [3:0] m_data;
    logic     m_valid;
    logic     m_ovr;

    task automatic model_reset();
        m_bits.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Apply one cycle of inputs to the 4-bit DUT, advance the model, return at negedge.
    task automatic tick4(input logic sin, input logic en, input logic clr, input logic rdy);
        logic       nv;
        logic [3:0] w;
        if4.serial_in  = sin;
        if4.sample_en  = en;
        if4.clear      = clr;
        if4.data_ready = rdy;
        @(posedge clk);
        nv = (m_valid && rdy) ? 1'b0 : m_valid;
        if (clr) begin
            m_bits.delete();
            m_ovr = 1'b0;
        end else if (en) begin
            m_bits.push_back(sin);
            if (m_bits.size() == 4) begin
                w = '0;
                foreach (m_bits[i]) w[i] = m_bits[i];
                m_bits.delete();
                if (!m_valid || rdy) begin
                    m_data = w;
                    nv     = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
        m_valid = nv;
        @(negedge clk);
    endtask

    task automatic send4(input logic [3:0] word, input logic rdy);
        for (int i = 0; i < 4; i++) tick4(word[i], 1'b1, 1'b0, rdy);
    endtask

    task automatic test_reset();
        if4.serial_in = 0; if4.sample_en = 0; if4.clear = 0; if4.data_ready = 0;
        if8.serial_in = 0; if8.sample_en = 0; if8.clear = 0; if8.data_ready = 0;
        model_reset();
        @(negedge clk);
        n_cmp++;
        if ({if4.data_valid, if4.overrun, if4.busy, if4.data_out} !== 7'b0) begin
            n_err++;
            $display("FAIL reset4 got=%b exp=0000000", {if4.data_valid, if4.overrun, if4.busy, if4.data_out});
        end
        n_cmp++;
        if ({if8.data_valid, if8.overrun, if8.busy, if8.data_out} !== 11'b0) begin
            n_err++;
            $display("FAIL reset8 got=%b exp=0", {if8.data_valid, if8.overrun, if8.busy, if8.data_out});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [3:0] b;
        b = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            tick4(b[i], 1'b1, 1'b0, 1'b1);
            n_cmp++;
            if (if4.data_valid !== (i == 3)) begin
                n_err++;
                $display("FAIL single_valid bit%0d got=%b exp=%b", i, if4.data_valid, (i == 3));
            end
        end
        n_cmp++;
        if (if4.data_out !== 4'b1011) begin
            n_err++;
            $display("FAIL single_data got=%h exp=b", if4.data_out);
        end
        tick4(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (if4.data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_pulse got=%b exp=0", if4.data_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] b;
        b = 4'h5;
        send4(4'hA, 1'b1);
        n_cmp++;
        if ({if4.data_valid, if4.data_out} !== 5'b1_1010) begin
            n_err++;
            $display("FAIL b2b_first got=%b exp=11010", {if4.data_valid, if4.data_out});
        end
        // Ready only on the last bit of the second word: transfer and reload coincide.
        for (int i = 0; i < 4; i++) begin
            tick4(b[i], 1'b1, 1'b0, (i == 3));
            n_cmp++;
            if ({if4.data_valid, if4.overrun, if4.data_out} !== ((i == 3) ? 6'b10_0101 : 6'b10_1010)) begin
                n_err++;
                $display("FAIL b2b_hold bit%0d got=%b exp=%b", i, {if4.data_valid, if4.overrun, if4.data_out},
                         ((i == 3) ? 6'b10_0101 : 6'b10_1010));
            end
        end
        tick4(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (if4.data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain got=%b exp=0", if4.data_valid);
        end
    endtask

    task automatic test_backpressure();
        send4(4'h3, 1'b0);
        n_cmp++;
        if ({if4.data_valid, if4.overrun, if4.data_out} !== 6'b10_0011) begin
            n_err++;
            $display("FAIL bp_first got=%b exp=100011", {if4.data_valid, if4.overrun, if4.data_out});
        end
        send4(4'hC, 1'b0);
        n_cmp++;
        if ({if4.data_valid, if4.overrun, if4.data_out} !== 6'b11_0011) begin
            n_err++;
            $display("FAIL bp_drop got=%b exp=110011", {if4.data_valid, if4.overrun, if4.data_out});
        end
        tick4(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({if4.data_valid, if4.overrun} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_consume got=%b exp=01", {if4.data_valid, if4.overrun});
        end
        tick4(1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (if4.overrun !== 1'b0) begin
            n_err++;
            $display("FAIL bp_clear got=%b exp=0", if4.overrun);
        end
    endtask

    task automatic test_realign();
        tick4(1'b1, 1'b1, 1'b0, 1'b1);
        tick4(1'b0, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (if4.busy !== 1'b1) begin
            n_err++;
            $display("FAIL realign_busy got=%b exp=1", if4.busy);
        end
        tick4(1'b0, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (if4.busy !== 1'b0) begin
            n_err++;
            $display("FAIL realign_clear got=%b exp=0", if4.busy);
        end
        send4(4'h6, 1'b1);
        n_cmp++;
        if ({if4.data_valid, if4.data_out} !== 5'b1_0110) begin
            n_err++;
            $display("FAIL realign_data got=%b exp=10110", {if4.data_valid, if4.data_out});
        end
        tick4(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        send4(4'h7, 1'b0);
        tick4(1'b1, 1'b1, 1'b0, 1'b0);
        tick4(1'b0, 1'b1, 1'b0, 1'b0);
        tick4(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({if4.data_valid, if4.busy, if4.data_out} !== 6'b11_0111) begin
            n_err++;
            $display("FAIL rstmid_pre got=%b exp=110111", {if4.data_valid, if4.busy, if4.data_out});
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({if4.data_valid, if4.overrun, if4.busy, if4.data_out} !== 7'b0) begin
            n_err++;
            $display("FAIL rstmid_async got=%b exp=0000000", {if4.data_valid, if4.overrun, if4.busy, if4.data_out});
        end
        model_reset();
        #1 reset_n = 1'b1;
        send4(4'h9, 1'b1);
        n_cmp++;
        if ({if4.data_valid, if4.busy, if4.data_out} !== 6'b10_1001) begin
            n_err++;
            $display("FAIL rstmid_next got=%b exp=101001", {if4.data_valid, if4.busy, if4.data_out});
        end
        tick4(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_gaps_w8();
        logic [7:0] w;
        w = 8'hC5;
        if8.data_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if8.serial_in = w[i];
            if8.sample_en = 1'b1;
            tick4(1'b0, 1'b0, 1'b0, 1'b1);
            if8.sample_en = 1'b0;
            n_cmp++;
            if ({if8.busy, if8.data_valid} !== ((i == 7) ? 2'b01 : 2'b10)) begin
                n_err++;
                $display("FAIL w8_bit%0d got=%b exp=%b", i, {if8.busy, if8.data_valid}, ((i == 7) ? 2'b01 : 2'b10));
            end
            if (i != 7) begin
                repeat ($urandom_range(1, 3)) begin
                    tick4(1'b0, 1'b0, 1'b0, 1'b1);
                    n_cmp++;
                    if ({if8.busy, if8.data_valid} !== 2'b10) begin
                        n_err++;
                        $display("FAIL w8_gap%0d got=%b exp=10", i, {if8.busy, if8.data_valid});
                    end
                end
            end
        end
        n_cmp++;
        if (if8.data_out !== 8'hC5) begin
            n_err++;
            $display("FAIL w8_data got=%h exp=c5", if8.data_out);
        end
        tick4(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (if8.data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL w8_drain got=%b exp=0", if8.data_valid);
        end
    endtask

    task automatic test_random();
        logic sin, en, clr, rdy;
        logic [6:0] exp_v;
        for (int c = 0; c < 400; c++) begin
            sin = 1'($urandom % 2);
            en  = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 29) == 0);
            rdy = (c < 200) ? 1'($urandom % 2) : ($urandom_range(0, 5) == 0);
            tick4(sin, en, clr, rdy);
            exp_v = {m_valid, m_ovr, (m_bits.size() != 0), m_data};
            n_cmp++;
            if ({if4.data_valid, if4.overrun, if4.busy, if4.data_out} !== exp_v) begin
                n_err++;
                $display("FAIL rand cyc%0d got=%b exp=%b (valid,ovr,busy,data)", c,
                         {if4.data_valid, if4.overrun, if4.busy, if4.data_out}, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_realign();
        test_reset_mid();
        test_gaps_w8();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sipo_deserializer
